// File: rtl/fighter_pkg.sv
// Shared fighter definitions: state codes, box geometry constants, box layout
// and saturating coordinate helpers.
package fighter_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CALC_W  = COORD_W + 1;
  localparam int unsigned BOX_W   = 4 * COORD_W;
  localparam int unsigned STATE_W = 4;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SPRITE_W    = 64;
  localparam int unsigned SPRITE_H    = 240;
  localparam int unsigned HURT_MARGIN = 3;
  localparam int unsigned HIT_W_BASIC = 50;
  localparam int unsigned HIT_H_BASIC = 45;
  localparam int unsigned HIT_W_DIR   = 40;
  localparam int unsigned HIT_H_DIR   = 120;

  // Fighter FSM state codes; any other code is neutral
  localparam logic [STATE_W-1:0] ST_ATK_ACTIVE = 4'd4;
  localparam logic [STATE_W-1:0] ST_ATK_REC    = 4'd5;
  localparam logic [STATE_W-1:0] ST_DIR_ACTIVE = 4'd7;
  localparam logic [STATE_W-1:0] ST_DIR_REC    = 4'd8;

  // Field offsets within a packed {x1,x2,y1,y2} box
  localparam int unsigned X1_LSB = 3 * COORD_W;
  localparam int unsigned X2_LSB = 2 * COORD_W;
  localparam int unsigned Y1_LSB = COORD_W;
  localparam int unsigned Y2_LSB = 0;

  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] y2;
  } box_t;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_CALC  = 2'd1,
    FSM_CHECK = 2'd2
  } fsm_t;

  // Clamp an x result to the last visible column
  function automatic logic [COORD_W-1:0] sat_x(input logic [CALC_W-1:0] v);
    return (v > CALC_W'(SCREEN_W - 1)) ? COORD_W'(SCREEN_W - 1) : v[COORD_W-1:0];
  endfunction

  // Clamp a y result to the coordinate range
  function automatic logic [COORD_W-1:0] sat_y(input logic [CALC_W-1:0] v);
    return v[COORD_W] ? '1 : v[COORD_W-1:0];
  endfunction

  // Subtract with floor at zero
  function automatic logic [CALC_W-1:0] sub_sat(input logic [CALC_W-1:0] a,
                                                input logic [CALC_W-1:0] b);
    return (a < b) ? '0 : (a - b);
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational box overlap test with strict inequalities (touching edges do
// not overlap).
//   a_box, b_box : packed {x1,x2,y1,y2} boxes
//   overlap_c    : 1 when the boxes share interior area
module box_overlap
  import fighter_pkg::*;
(
  input  logic [BOX_W-1:0] a_box,
  input  logic [BOX_W-1:0] b_box,
  output logic             overlap_c
);

  logic [COORD_W-1:0] a_x1, a_x2, a_y1, a_y2;
  logic [COORD_W-1:0] b_x1, b_x2, b_y1, b_y2;

  assign a_x1 = a_box[X1_LSB +: COORD_W];
  assign a_x2 = a_box[X2_LSB +: COORD_W];
  assign a_y1 = a_box[Y1_LSB +: COORD_W];
  assign a_y2 = a_box[Y2_LSB +: COORD_W];
  assign b_x1 = b_box[X1_LSB +: COORD_W];
  assign b_x2 = b_box[X2_LSB +: COORD_W];
  assign b_y1 = b_box[Y1_LSB +: COORD_W];
  assign b_y2 = b_box[Y2_LSB +: COORD_W];

  assign overlap_c = (a_x1 < b_x2) && (b_x1 < a_x2) &&
                     (a_y1 < b_y2) && (b_y1 < a_y2);

endmodule

// File: rtl/fighter_box_engine.sv
// Frame-synchronous per-fighter box engine. On frame_tick it captures the
// fighter state and position, computes saturated hit/hurt/recovery/overlay
// boxes one cycle later, then checks its hitbox against the opponent's
// hurtboxes and emits one hit pulse per attack instance.
//   inputs : clk, rst_n, frame_tick, state, sprite_x, sprite_y, facing_left,
//            opp_hurt, opp_rec, opp_rec_active
//   outputs: hit_box/hit_active, hurt_box, rec_box/rec_active,
//            vis_box/vis_active, boxes_valid, hit_pulse, hit_latched,
//            tick_overrun (all registered)
module fighter_box_engine
  import fighter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [3:0]         state,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic               facing_left,
  input  logic [BOX_W-1:0]   opp_hurt,
  input  logic [BOX_W-1:0]   opp_rec,
  input  logic               opp_rec_active,
  output logic [BOX_W-1:0]   hit_box,
  output logic               hit_active,
  output logic [BOX_W-1:0]   hurt_box,
  output logic [BOX_W-1:0]   rec_box,
  output logic               rec_active,
  output logic [BOX_W-1:0]   vis_box,
  output logic               vis_active,
  output logic               boxes_valid,
  output logic               hit_pulse,
  output logic               hit_latched,
  output logic               tick_overrun
);

  localparam logic [CALC_W-1:0] SPRITE_W_C  = CALC_W'(SPRITE_W);
  localparam logic [CALC_W-1:0] SPRITE_H_C  = CALC_W'(SPRITE_H);
  localparam logic [CALC_W-1:0] MARGIN_C    = CALC_W'(HURT_MARGIN);
  localparam logic [CALC_W-1:0] BASIC_W_C   = CALC_W'(HIT_W_BASIC);
  localparam logic [CALC_W-1:0] BASIC_H_C   = CALC_W'(HIT_H_BASIC);
  localparam logic [CALC_W-1:0] DIR_W_C     = CALC_W'(HIT_W_DIR);
  localparam logic [CALC_W-1:0] DIR_H_C     = CALC_W'(HIT_H_DIR);
  localparam logic [CALC_W-1:0] BASIC_YOFF_C = CALC_W'((SPRITE_H - HIT_H_BASIC) / 2);
  localparam logic [CALC_W-1:0] DIR_YOFF_C   = CALC_W'(SPRITE_H - HIT_H_DIR);

  fsm_t               fsm_q, fsm_d;
  logic [3:0]         cap_state_q, cap_state_d;
  logic [COORD_W-1:0] cap_x_q, cap_x_d;
  logic [COORD_W-1:0] cap_y_q, cap_y_d;
  logic               cap_left_q, cap_left_d;

  box_t hit_box_q, hit_box_d;
  box_t hurt_box_q, hurt_box_d;
  box_t rec_box_q, rec_box_d;
  box_t vis_box_q, vis_box_d;
  logic hit_active_q, hit_active_d;
  logic rec_active_q, rec_active_d;
  logic vis_active_q, vis_active_d;
  logic boxes_valid_q, boxes_valid_d;
  logic hit_pulse_q, hit_pulse_d;
  logic hit_latched_q, hit_latched_d;
  logic tick_overrun_q, tick_overrun_d;

  // Geometry derived from the captured fighter snapshot
  logic              is_dir, is_act, is_rec;
  logic [CALC_W-1:0] x_w, y_w, atk_w, atk_h, atk_yoff;
  logic [CALC_W-1:0] ax1, ax2, ay1, ay2;
  box_t              geo_box, body_box;

  always_comb begin
    is_dir   = (cap_state_q == ST_DIR_ACTIVE) || (cap_state_q == ST_DIR_REC);
    is_act   = (cap_state_q == ST_ATK_ACTIVE) || (cap_state_q == ST_DIR_ACTIVE);
    is_rec   = (cap_state_q == ST_ATK_REC)    || (cap_state_q == ST_DIR_REC);
    x_w      = CALC_W'(cap_x_q);
    y_w      = CALC_W'(cap_y_q);
    atk_w    = is_dir ? DIR_W_C    : BASIC_W_C;
    atk_h    = is_dir ? DIR_H_C    : BASIC_H_C;
    atk_yoff = is_dir ? DIR_YOFF_C : BASIC_YOFF_C;

    // Attack extends away from the body in the facing direction
    if (cap_left_q) begin
      ax1 = sub_sat(x_w, atk_w);
      ax2 = x_w;
    end else begin
      ax1 = x_w + SPRITE_W_C;
      ax2 = ax1 + atk_w;
    end
    ay1 = y_w + atk_yoff;
    ay2 = ay1 + atk_h;

    geo_box.x1 = sat_x(ax1);
    geo_box.x2 = sat_x(ax2);
    geo_box.y1 = sat_y(ay1);
    geo_box.y2 = sat_y(ay2);

    body_box.x1 = sat_x(x_w + MARGIN_C);
    body_box.x2 = sat_x(x_w + SPRITE_W_C - MARGIN_C);
    body_box.y1 = cap_y_q;
    body_box.y2 = sat_y(y_w + SPRITE_H_C);
  end

  logic ov_hurt_c, ov_rec_c;

  box_overlap u_ov_hurt (
    .a_box     (hit_box_q),
    .b_box     (opp_hurt),
    .overlap_c (ov_hurt_c)
  );

  box_overlap u_ov_rec (
    .a_box     (hit_box_q),
    .b_box     (opp_rec),
    .overlap_c (ov_rec_c)
  );

  // Next-state and output logic
  always_comb begin
    fsm_d          = fsm_q;
    cap_state_d    = cap_state_q;
    cap_x_d        = cap_x_q;
    cap_y_d        = cap_y_q;
    cap_left_d     = cap_left_q;
    hit_box_d      = hit_box_q;
    hurt_box_d     = hurt_box_q;
    rec_box_d      = rec_box_q;
    vis_box_d      = vis_box_q;
    hit_active_d   = hit_active_q;
    rec_active_d   = rec_active_q;
    vis_active_d   = vis_active_q;
    boxes_valid_d  = 1'b0;
    hit_pulse_d    = 1'b0;
    hit_latched_d  = hit_latched_q;
    tick_overrun_d = tick_overrun_q;

    unique case (fsm_q)
      FSM_IDLE: begin
        if (frame_tick) begin
          cap_state_d = state;
          cap_x_d     = sprite_x;
          cap_y_d     = sprite_y;
          cap_left_d  = facing_left;
          fsm_d       = FSM_CALC;
        end
      end
      FSM_CALC: begin
        hurt_box_d    = body_box;
        hit_active_d  = is_act;
        rec_active_d  = is_rec;
        hit_box_d     = is_act ? geo_box : '0;
        rec_box_d     = is_rec ? geo_box : '0;
        vis_active_d  = is_act | is_rec;
        vis_box_d     = (is_act | is_rec) ? geo_box : '0;
        boxes_valid_d = 1'b1;
        // A neutral state ends the attack instance and re-arms hit detection
        if (!(is_act | is_rec)) hit_latched_d = 1'b0;
        if (frame_tick) tick_overrun_d = 1'b1;
        fsm_d = FSM_CHECK;
      end
      FSM_CHECK: begin
        if (hit_active_q && !hit_latched_q &&
            (ov_hurt_c || (opp_rec_active && ov_rec_c))) begin
          hit_pulse_d   = 1'b1;
          hit_latched_d = 1'b1;
        end
        if (frame_tick) tick_overrun_d = 1'b1;
        fsm_d = FSM_IDLE;
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q          <= FSM_IDLE;
      cap_state_q    <= '0;
      cap_x_q        <= '0;
      cap_y_q        <= '0;
      cap_left_q     <= 1'b0;
      hit_box_q      <= '0;
      hurt_box_q     <= '0;
      rec_box_q      <= '0;
      vis_box_q      <= '0;
      hit_active_q   <= 1'b0;
      rec_active_q   <= 1'b0;
      vis_active_q   <= 1'b0;
      boxes_valid_q  <= 1'b0;
      hit_pulse_q    <= 1'b0;
      hit_latched_q  <= 1'b0;
      tick_overrun_q <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      cap_state_q    <= cap_state_d;
      cap_x_q        <= cap_x_d;
      cap_y_q        <= cap_y_d;
      cap_left_q     <= cap_left_d;
      hit_box_q      <= hit_box_d;
      hurt_box_q     <= hurt_box_d;
      rec_box_q      <= rec_box_d;
      vis_box_q      <= vis_box_d;
      hit_active_q   <= hit_active_d;
      rec_active_q   <= rec_active_d;
      vis_active_q   <= vis_active_d;
      boxes_valid_q  <= boxes_valid_d;
      hit_pulse_q    <= hit_pulse_d;
      hit_latched_q  <= hit_latched_d;
      tick_overrun_q <= tick_overrun_d;
    end
  end

  assign hit_box      = hit_box_q;
  assign hit_active   = hit_active_q;
  assign hurt_box     = hurt_box_q;
  assign rec_box      = rec_box_q;
  assign rec_active   = rec_active_q;
  assign vis_box      = vis_box_q;
  assign vis_active   = vis_active_q;
  assign boxes_valid  = boxes_valid_q;
  assign hit_pulse    = hit_pulse_q;
  assign hit_latched  = hit_latched_q;
  assign tick_overrun = tick_overrun_q;

endmodule
